// File: rtl/uart_tx_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter_if
//  Brief    : Requester byte-stream and uart_tx handshake bundle for the
//             uart_tx_arbiter (master = arbiter, slave = requesters/uart_tx).
//  Revision : 1.0  initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_send_request;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        input  req_valid,
        input  req_data,
        input  req_last,
        output req_ready,
        output tx_send_request,
        output tx_data,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        output req_valid,
        output req_data,
        output req_last,
        input  req_ready,
        input  tx_send_request,
        input  tx_data,
        output tx_busy,
        output tx_done
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Brief    : Packet-granular round-robin sharing of one uart_tx between
//             NUM_REQ byte requesters, with a per-byte tx_done watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WDOG_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    uart_tx_arbiter_if.master          bus,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       err_timeout
);

    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_ISSUE     = 2'd1;
    localparam logic [1:0] c_WAIT_DONE = 2'd2;

    localparam logic [WDOG_W-1:0] c_WDOG_MAX = '1;
    localparam logic [ID_W-1:0]   c_LAST_ID  = ID_W'(NUM_REQ - 1);

    logic [1:0]        r_state;
    logic [ID_W-1:0]   r_grant_id;
    logic              r_grant_valid;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_err_timeout;
    logic              r_send;
    logic [7:0]        r_tx_data;
    logic              r_last;

    logic              w_any_valid;
    logic [ID_W-1:0]   w_winner;
    logic              w_found;
    logic              w_gnt_valid;
    logic              w_gnt_last;
    logic [7:0]        w_gnt_data;
    logic              w_accept;
    logic [NUM_REQ-1:0] w_ready;
    logic [ID_W-1:0]   w_rr_next;

    assign w_any_valid = |bus.req_valid;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin : p_winner
        logic [ID_W-1:0] v_idx;
        w_winner = r_rr_ptr;
        w_found  = 1'b0;
        v_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end
        end
    end

    assign w_gnt_valid = bus.req_valid[r_grant_id];
    assign w_gnt_last  = bus.req_last[r_grant_id];
    assign w_gnt_data  = bus.req_data[int'(r_grant_id)*8 +: 8];

    always_comb begin : p_ready
        w_ready = '0;
        if (r_state == c_ISSUE) begin
            w_ready[r_grant_id] = !bus.tx_busy;
        end
    end

    assign w_accept  = (r_state == c_ISSUE) && w_gnt_valid && !bus.tx_busy;
    assign w_rr_next = (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + 1'b1;

    always_ff @(posedge clk) begin : p_fsm
        if (!reset_n) begin
            r_state       <= c_IDLE;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= '0;
            r_wdog        <= '0;
            r_err_timeout <= 1'b0;
            r_send        <= 1'b0;
            r_tx_data     <= 8'h00;
            r_last        <= 1'b0;
        end else begin
            r_send        <= 1'b0;
            r_err_timeout <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_any_valid) begin
                        r_grant_id    <= w_winner;
                        r_grant_valid <= 1'b1;
                        r_state       <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (w_accept) begin
                        r_tx_data <= w_gnt_data;
                        r_send    <= 1'b1;
                        r_last    <= w_gnt_last;
                        r_wdog    <= '0;
                        r_state   <= c_WAIT_DONE;
                    end
                end
                c_WAIT_DONE: begin
                    r_wdog <= r_wdog + 1'b1;
                    // tx_done takes priority over a watchdog expiry in the same cycle.
                    if (bus.tx_done) begin
                        if (r_last) begin
                            r_grant_valid <= 1'b0;
                            r_rr_ptr      <= w_rr_next;
                            r_state       <= c_IDLE;
                        end else begin
                            r_state <= c_ISSUE;
                        end
                    end else if (r_wdog == c_WDOG_MAX) begin
                        r_err_timeout <= 1'b1;
                        r_grant_valid <= 1'b0;
                        r_rr_ptr      <= w_rr_next;
                        r_state       <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready       = w_ready;
    assign bus.tx_send_request = r_send;
    assign bus.tx_data         = r_tx_data;
    assign grant_valid         = r_grant_valid;
    assign grant_id            = r_grant_id;
    assign err_timeout         = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Brief    : Scoreboard bench for uart_tx_arbiter with requester queues and
//             a behavioural uart_tx responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WDOG_W  = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       err_timeout;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WDOG_W  (WDOG_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Requester byte queues: {last, data}
    logic [8:0] rmem [NUM_REQ][32];
    int         rhead [NUM_REQ];
    int         rtail [NUM_REQ];
    logic [9:0] exp_q [$];

    task automatic push_byte(input int id, input logic [7:0] d, input logic last);
        rmem[id][rtail[id] % 32] = {last, d};
        rtail[id]++;
    endtask

    task automatic expect_byte(input int id, input logic [7:0] d);
        exp_q.push_back({2'(id), d});
    endtask

    initial begin
        logic [NUM_REQ-1:0] fire;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            fire = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fire[i]) rhead[i]++;
                if (rhead[i] != rtail[i]) begin
                    bus.req_valid[i]       = 1'b1;
                    bus.req_data[8*i +: 8] = rmem[i][rhead[i] % 32][7:0];
                    bus.req_last[i]        = rmem[i][rhead[i] % 32][8];
                end else begin
                    bus.req_valid[i] = 1'b0;
                    bus.req_last[i]  = 1'b0;
                end
            end
        end
    end

    // uart_tx responder; done_dly < 0 withholds tx_done forever
    int  done_dly = 0;
    bit  busy_en  = 1'b1;
    bit  pending  = 1'b0;
    int  cnt      = 0;
    int  n_sends  = 0;
    int  last_send_cyc = 0;
    int  gaps [$];

    initial begin
        logic [9:0] e;
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_done = 1'b0;
            if (bus.tx_send_request) begin
                n_sends++;
                gaps.push_back(cyc - last_send_cyc);
                last_send_cyc = cyc;
                chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_id_data", {22'd0, grant_id, bus.tx_data}, {22'd0, e});
                end
                pending     = 1'b1;
                cnt         = done_dly;
                bus.tx_busy = busy_en;
            end else if (pending && cnt == 0) begin
                bus.tx_done = 1'b1;
                bus.tx_busy = 1'b0;
                pending     = 1'b0;
            end else if (pending && cnt > 0) begin
                cnt--;
            end
        end
    end

    int err_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (err_timeout) err_cnt++;
    end

    task automatic wait_drain(input string tag, input int max);
        int k;
        bit ok;
        k  = 0;
        ok = 1'b0;
        while (!ok && k < max) begin
            @(negedge clk);
            k++;
            ok = (exp_q.size() == 0) && !grant_valid;
        end
        chk(tag, 32'(ok), 1);
    endtask

    task automatic wait_send(input string tag, input int max);
        int k;
        bit ok;
        k  = 0;
        ok = 1'b0;
        while (!ok && k < max) begin
            @(negedge clk);
            k++;
            ok = bus.tx_send_request;
        end
        chk(tag, 32'(ok), 1);
    endtask

    initial begin
        int  s_sends;
        int  s_err;
        int  k;
        bit  seen;

        // Reset
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant_valid", 32'(grant_valid), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_send", 32'(bus.tx_send_request), 0);
        chk("rst_tx_data", 32'(bus.tx_data), 0);
        chk("rst_err", 32'(err_timeout), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        reset_n = 1'b1;

        // Round-robin from pointer 0 over requesters 0,1,3
        @(negedge clk);
        push_byte(0, 8'h01, 1'b1); push_byte(1, 8'h02, 1'b1); push_byte(3, 8'h03, 1'b1);
        push_byte(0, 8'h04, 1'b1); push_byte(1, 8'h05, 1'b1); push_byte(3, 8'h06, 1'b1);
        expect_byte(0, 8'h01); expect_byte(1, 8'h02); expect_byte(3, 8'h03);
        expect_byte(0, 8'h04); expect_byte(1, 8'h05); expect_byte(3, 8'h06);
        wait_drain("rr_drain", 100);

        // Single byte timing
        @(negedge clk);
        push_byte(2, 8'hA5, 1'b1);
        expect_byte(2, 8'hA5);
        @(negedge clk);
        chk("single_idle_gv", 32'(grant_valid), 0);
        @(negedge clk);
        chk("single_grant_valid", 32'(grant_valid), 1);
        chk("single_grant_id", 32'(grant_id), 2);
        chk("single_ready", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        chk("single_send", 32'(bus.tx_send_request), 1);
        chk("single_tx_data", 32'(bus.tx_data), 32'hA5);
        chk("single_ready_wait", 32'(bus.req_ready), 0);
        @(negedge clk);
        chk("single_send_pulse", 32'(bus.tx_send_request), 0);
        wait_drain("single_drain", 20);
        chk("single_data_hold", 32'(bus.tx_data), 32'hA5);

        // Packet lock: requester 1 three bytes, requester 0 waiting
        gaps.delete();
        @(negedge clk);
        push_byte(1, 8'h11, 1'b0); push_byte(1, 8'h22, 1'b0); push_byte(1, 8'h33, 1'b1);
        expect_byte(1, 8'h11); expect_byte(1, 8'h22); expect_byte(1, 8'h33);
        expect_byte(0, 8'h44);
        @(negedge clk);
        push_byte(0, 8'h44, 1'b1);
        wait_drain("lock_drain", 60);
        chk("lock_nsends", 32'(gaps.size()), 4);
        if (gaps.size() == 4) begin
            chk("lock_gap_b2", 32'(gaps[1]), 3);
            chk("lock_gap_b3", 32'(gaps[2]), 3);
            chk("lock_gap_rearb", 32'(gaps[3]), 4);
        end

        // Watchdog expiry on a withheld tx_done
        done_dly = -1;
        busy_en  = 1'b0;
        @(negedge clk);
        push_byte(1, 8'hAA, 1'b0); push_byte(1, 8'hBB, 1'b1); push_byte(2, 8'hCC, 1'b1);
        expect_byte(1, 8'hAA); expect_byte(2, 8'hCC); expect_byte(1, 8'hBB);
        wait_send("wd_send", 10);
        done_dly = 0;
        busy_en  = 1'b1;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            seen = err_timeout;
        end
        chk("wd_err_seen", 32'(seen), 1);
        if (seen) begin
            chk("wd_err_latency", 32'(cyc - last_send_cyc), 16);
            chk("wd_grant_released", 32'(grant_valid), 0);
        end
        wait_drain("wd_drain", 60);
        chk("wd_err_count", 32'(err_cnt), 1);

        // tx_done on the final watchdog count wins
        done_dly = 14;
        @(negedge clk);
        push_byte(3, 8'hDD, 1'b1);
        expect_byte(3, 8'hDD);
        wait_drain("wd_edge_drain", 60);
        chk("wd_edge_no_err", 32'(err_cnt), 1);

        // Mid-operation reset, then stale tx_done
        done_dly = 0;
        @(negedge clk);
        push_byte(1, 8'h5A, 1'b1);
        expect_byte(1, 8'h5A);
        wait_drain("mr_pre_drain", 20);
        done_dly = 3;
        @(negedge clk);
        push_byte(2, 8'hEE, 1'b1);
        expect_byte(2, 8'hEE);
        wait_send("mr_send", 10);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("mr_grant_valid", 32'(grant_valid), 0);
        chk("mr_grant_id", 32'(grant_id), 0);
        chk("mr_send", 32'(bus.tx_send_request), 0);
        chk("mr_tx_data", 32'(bus.tx_data), 0);
        s_sends = n_sends;
        s_err   = err_cnt;
        repeat (8) @(negedge clk);
        chk("mr_stale_no_send", 32'(n_sends), 32'(s_sends));
        chk("mr_stale_idle", 32'(grant_valid), 0);
        chk("mr_stale_no_err", 32'(err_cnt), 32'(s_err));
        done_dly = 0;
        @(negedge clk);
        push_byte(3, 8'hFF, 1'b1); push_byte(1, 8'h77, 1'b1);
        expect_byte(1, 8'h77); expect_byte(3, 8'hFF);
        wait_drain("mr_post_drain", 40);

        chk("sb_empty_end", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete, got t=%0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
